// File: rtl/simplearm_pkg.sv
// Shared types and constants for the SimpleARM fetch front end.
package simplearm_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {instr, pc} entries; flush beats push in the same cycle.
module fetch_queue
    import simplearm_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(QDEPTH):0]  count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem [QDEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(QDEPTH));
    assign push_ok = push & ~flush & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage is cleared on reset so the head never reads as X
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, request FSM and prefetch queue feeding decode.
module fetch_unit
    import simplearm_pkg::*;
#(
    parameter int unsigned QDEPTH   = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRD,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] InstrPCPlus8,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        Fault
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_t    state;
    logic [31:0]     fetch_pc;
    logic            req;
    logic            push;
    logic            pop;
    logic            aligned;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   next_count;
    logic            q_empty;
    logic            q_full;
    fetch_entry_t    q_head;
    fetch_entry_t    q_in;

    // Request follows registered state only; reset holds it low
    assign req        = (state == FETCH) & ~reset;
    assign push       = req & ImemAck & ~Redirect & ~q_full;
    assign pop        = ~q_empty & InstrReady;
    assign aligned    = (RedirectPC[1:0] == 2'b00);
    assign next_count = q_count + CW'(push) - CW'(pop);
    assign q_in       = '{instr: ImemRD, pc: fetch_pc};

    assign ImemReq      = req;
    assign ImemAddr     = fetch_pc;
    assign InstrValid   = ~q_empty;
    assign Instr        = q_head.instr;
    assign InstrPC      = q_head.pc;
    assign InstrPCPlus8 = q_head.pc + 32'd8;
    assign Fault        = (state == FAULT);

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (q_in),
        .pop       (pop),
        .flush     (Redirect),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // Fetch FSM and PC; a redirect overrides any ack in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
        end else if (Redirect) begin
            if (aligned) begin
                state    <= FETCH;
                fetch_pc <= RedirectPC;
            end else begin
                state    <= FAULT;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (push) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (next_count == CW'(QDEPTH)) begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (next_count < CW'(QDEPTH)) begin
                        state <= FETCH;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;

    localparam int          QD     = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRD;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic [31:0] InstrPCPlus8;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Fault;

    fetch_unit #(
        .QDEPTH   (QD),
        .RESET_PC (RST_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemAck      (ImemAck),
        .ImemRD       (ImemRD),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrPCPlus8 (InstrPCPlus8),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .Fault        (Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queued words with their addresses, next fetch address, fault flag
    logic [31:0] m_instr [$];
    logic [31:0] m_pc    [$];
    logic [31:0] m_fetch_pc;
    bit          m_fault;
    int          wait_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs();
        bit exp_req;
        bit exp_valid;
        exp_req   = !reset && !m_fault && (m_pc.size() < QD);
        exp_valid = (m_pc.size() > 0);
        check("ImemReq", 32'(ImemReq), 32'(exp_req));
        if (exp_req) check("ImemAddr", ImemAddr, m_fetch_pc);
        check("InstrValid", 32'(InstrValid), 32'(exp_valid));
        check("Fault", 32'(Fault), 32'(m_fault));
        if (exp_valid) begin
            check("Instr", Instr, m_instr[0]);
            check("InstrPC", InstrPC, m_pc[0]);
            check("InstrPCPlus8", InstrPCPlus8, m_pc[0] + 32'd8);
        end
        check("no_x", 32'($isunknown({Instr, InstrPC, InstrPCPlus8, ImemAddr})), 32'd0);
    endtask

    // One clock: compare at negedge, drive inputs, advance model at posedge
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                        input bit rdy, input int lat);
        bit          exp_req;
        bit          ack;
        bit          pop;
        logic [31:0] rd;
        @(negedge clk);
        compare_outputs();
        exp_req    = !rst && !m_fault && (m_pc.size() < QD);
        ack        = exp_req && (wait_cnt >= lat);
        pop        = (m_pc.size() > 0) && rdy;
        rd         = $urandom;
        reset      = rst;
        Redirect   = redir;
        RedirectPC = rpc;
        InstrReady = rdy;
        ImemAck    = ack || (!exp_req && ($urandom_range(0, 3) == 0));
        ImemRD     = rd;
        @(posedge clk);
        if (rst) begin
            m_instr.delete();
            m_pc.delete();
            m_fetch_pc = RST_PC;
            m_fault    = 1'b0;
        end else if (redir) begin
            m_instr.delete();
            m_pc.delete();
            if (rpc[1:0] == 2'b00) begin
                m_fetch_pc = rpc;
                m_fault    = 1'b0;
            end else begin
                m_fault    = 1'b1;
            end
        end else begin
            if (pop) begin
                void'(m_instr.pop_front());
                void'(m_pc.pop_front());
            end
            if (ack) begin
                m_instr.push_back(rd);
                m_pc.push_back(m_fetch_pc);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        if (rst || redir || ack) wait_cnt = 0;
        else if (exp_req)        wait_cnt++;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] rpc;
        bit          rst;
        bit          redir;
        bit          rdy;
        int          lat;

        reset = 1'b1; Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b0;
        ImemAck = 1'b0; ImemRD = '0;
        m_fetch_pc = RST_PC; m_fault = 1'b0; wait_cnt = 0;

        step(1, 0, 32'h0, 0, 0);
        step(1, 0, 32'h0, 0, 0);

        // Zero-wait streaming right after reset
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 1, 0);
            #1;
            check("tp_stream_valid", 32'(InstrValid), 32'd1);
            check("tp_stream_pc", InstrPC, 32'(4 * i));
            check("tp_stream_pc8", InstrPCPlus8, 32'h8 + 32'(4 * i));
        end

        // Consumer stall fills the queue and stops requests
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0, 0);
        #1;
        check("tp_full_req", 32'(ImemReq), 32'd0);
        check("tp_full_valid", 32'(InstrValid), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 0);

        // Aligned redirect with an ack in the same cycle
        step(0, 1, 32'h100, 1, 0);
        #1;
        check("tp_redir_addr", ImemAddr, 32'h100);
        check("tp_redir_valid", 32'(InstrValid), 32'd0);
        step(0, 0, 32'h0, 1, 0);
        #1;
        check("tp_redir_first_valid", 32'(InstrValid), 32'd1);
        check("tp_redir_first_pc", InstrPC, 32'h100);

        // Misaligned redirect faults until an aligned one
        step(0, 1, 32'h102, 1, 0);
        #1;
        check("tp_fault_set", 32'(Fault), 32'd1);
        check("tp_fault_req", 32'(ImemReq), 32'd0);
        check("tp_fault_valid", 32'(InstrValid), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0);
        step(0, 1, 32'h200, 1, 0);
        #1;
        check("tp_fault_clear", 32'(Fault), 32'd0);
        check("tp_fault_resume", ImemAddr, 32'h200);

        // Slow memory: three wait cycles per request
        for (int i = 0; i < 20; i++) step(0, 0, 32'h0, 1, 3);

        // Reset with the queue full
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 0);
        step(1, 0, 32'h0, 0, 0);
        #1;
        check("tp_rst_valid", 32'(InstrValid), 32'd0);
        check("tp_rst_fault", 32'(Fault), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0);

        // Randomized traffic
        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) lat = int'($urandom_range(0, 3));
            rst   = ($urandom_range(0, 99) == 0);
            redir = ($urandom_range(0, 19) == 0);
            rdy   = ($urandom_range(0, 2) != 0);
            r     = $urandom;
            rpc   = {r[31:2], 2'b00};
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(rst, redir, rpc, rdy, lat);
        end

        @(negedge clk);
        compare_outputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the SimpleARM core. It produces the 32-bit instruction words that the decoder consumes: the PC is held here, requests go to instruction memory, and responses are buffered in a small prefetch queue. Words are handed to the decode stage over a valid/ready handshake. The queue is flushed and fetch restarts when the datapath signals a PC write (branch or write to R15).

## Interface
- QDEPTH, 2, prefetch queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, fetch address after reset

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- ImemReq  out  1  fetch request to instruction memory
- ImemAddr  out  32  word address of request (bits [1:0] always 0)
- ImemAck  in  1  memory accepts request; ImemRD valid this cycle
- ImemRD  in  32  instruction word returned
- InstrValid  out  1  queue head valid
- InstrReady  in  1  decode stage accepts head
- Instr  out  32  head instruction word
- InstrPC  out  32  address of head instruction
- InstrPCPlus8  out  32  InstrPC + 8 (ARM R15 read value), modulo 2^32
- Redirect  in  1  PC write from datapath (PCS asserted, instruction committed)
- RedirectPC  in  32  new fetch address
- Fault  out  1  misaligned redirect seen; fetch halted

## Operation
- FSM states: FETCH, FULL, FAULT.
- FETCH: ImemReq=1, ImemAddr=FetchPC. On ImemAck: push {ImemRD, FetchPC}; FetchPC += 4 (wraps at 2^32). Go to FULL if count after push/pop equals QDEPTH.
- FULL: ImemReq=0. Return to FETCH when count < QDEPTH.
- Request is issued only when the registered count < QDEPTH, so a push never overflows.
- ImemReq/ImemAddr stay stable until ImemAck. Only Redirect, reset or Fault may withdraw them.
- Pop when InstrValid & InstrReady. Instr, InstrPC and InstrPCPlus8 come from the queue head. Their values are don't-care when InstrValid=0 but must not be X.
- Redirect with RedirectPC[1:0]==0: flush queue, FetchPC <= RedirectPC, state <= FETCH. Any ImemAck in the same cycle is discarded.
- Redirect with RedirectPC[1:0]!=0: flush queue, state <= FAULT, Fault=1, ImemReq=0.
- FAULT: stays until reset or an aligned Redirect. An aligned Redirect clears Fault and resumes FETCH at RedirectPC.
- Simultaneous pop and push: count unchanged, both take effect.
- Simultaneous Redirect and pop: the consumer's transfer counts. The queue is empty next cycle regardless.
- Simultaneous Redirect and reset: reset wins.

## Timing
- Reset values: FetchPC=RESET_PC, queue empty, InstrValid=0, ImemReq=0 while reset=1, Fault=0, state=FETCH.
- First cycle after reset deasserts: ImemReq=1, ImemAddr=RESET_PC.
- ImemAck in cycle n: the instruction is at the head with InstrValid=1 in cycle n+1 (queue was empty).
- Zero-wait memory with InstrReady held high: 1 instruction per cycle sustained.
- Redirect in cycle n: cycle n+1 has InstrValid=0 and ImemAddr=RedirectPC. The first new instruction is valid at n+2 with zero-wait memory.
- InstrValid is a registered-state function only. There is no combinational path from Redirect or InstrReady to InstrValid, Instr or ImemReq.

## Structure
- simplearm_pkg: fetch_state_t enum (FETCH, FULL, FAULT), fetch_entry_t struct {instr[31:0], pc[31:0]}, RESET_PC default constant.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty/full. Flush has priority over push in the same cycle.
- fetch_unit holds FetchPC, the FSM, request logic and the PCPlus8 adder.

## Test plan
- Reset, zero-wait memory, InstrReady=1: words at 0x0, 0x4, 0x8 appear on consecutive cycles starting one cycle after the first ack; InstrPCPlus8=0x8, 0xC, 0x10.
- InstrReady=0 for 5 cycles: exactly QDEPTH=2 entries accepted, ImemReq drops, state FULL. Raise InstrReady: order preserved, fetch resumes at 0x8.
- Redirect to 0x100 with ack pending in the same cycle: acked word dropped, next ImemAddr=0x100, first valid InstrPC=0x100 two cycles later.
- Redirect to 0x102: Fault=1 next cycle, ImemReq=0, InstrValid=0. A later Redirect to 0x200 clears Fault and fetches 0x200.
- Memory with 3-cycle ack latency: ImemAddr stable across the wait cycles, no duplicate push, PC sequence contiguous.
- Reset asserted mid-stream with 2 entries queued: cycle after reset shows InstrValid=0 and Fault=0; fetch restarts at RESET_PC.
